inst_fetch_unit: RTL
====================

Name: inst_fetch_unit

Overview:
- Producer end of the 16-bit instruction interface consumed by the instruction decoder/controller.
- Holds the PC and fetches from instruction memory over a req/ack handshake.
- Presents one instruction at a time to the decoder over a valid/ready handshake.
- Consumes the decoder's PcSrc/Branch outputs and the ALU zero flag to select the next PC (sequential, jump, or beq).

Parameters:
- PC_W, 12, PC and instruction-memory address width (word-addressed).
- INST_W, 16, instruction width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  PC_W  fetch address; equals pc.
- imem_ack  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  INST_W  fetched instruction word.
- inst  out  INST_W  instruction presented to the decoder.
- inst_valid  out  1  inst and pc are valid.
- inst_ready  in  1  decoder/datapath accepts inst this cycle.
- pc  out  PC_W  address of the instruction being fetched or presented.
- pc_src  in  2  decoder PcSrc: 0 = sequential, 1 = jump, 2/3 illegal.
- branch  in  1  decoder Branch (beq).
- zero  in  1  ALU zero flag, valid in the handshake cycle.
- halt  in  1  stop fetching after the current instruction.
- retired_cnt  out  16  count of accepted instructions.
- illegal_pcsrc  out  1  sticky; set when pc_src is 2 or 3 at a handshake.

Behaviour:
- Reset (async, rst_n low):
  - pc = RESET_PC, state = IDLE.
  - imem_req = 0, inst_valid = 0, inst = 0, retired_cnt = 0, illegal_pcsrc = 0.
  - Outputs clear immediately, including during an outstanding fetch; a late imem_ack after reset is ignored.
- FSM states: IDLE, FETCH, ISSUE.
- IDLE:
  - imem_req = 0, inst_valid = 0.
  - halt = 0 → FETCH next cycle; otherwise stay.
- FETCH:
  - imem_req = 1, imem_addr = pc, both held stable until ack.
  - imem_ack = 1 (may arrive in the first FETCH cycle) → inst <= imem_rdata, go to ISSUE.
  - imem_req drops in the next cycle.
  - A started fetch always completes; halt never abandons it.
- ISSUE:
  - inst_valid = 1; inst and pc held stable until inst_ready.
  - imem_ack in ISSUE or IDLE is ignored.
- Handshake (inst_valid & inst_ready):
  - pc_src, branch and zero are sampled; next_pc is computed as:
    - pc_src == 1 → next_pc = inst[PC_W-1:0] (jump target field).
    - else branch & zero → next_pc = pc + 1 + sign_extend(inst[7:0]).
    - else next_pc = pc + 1.
    - pc_src 2/3 → treated as sequential, and illegal_pcsrc is set.
  - pc_src == 1 takes priority over branch if both are asserted.
  - All PC arithmetic is modulo 2^PC_W (wraps silently, e.g. 0xFFF + 1 → 0x000; offset 0x80 at pc 0 → 0xF81).
  - pc <= next_pc; retired_cnt <= retired_cnt + 1 (wraps at 16 bits).
  - Next state: halt = 1 → IDLE, else FETCH.
- Throughput and latency:
  - Zero-wait memory with inst_ready held high gives 1 instruction per 2 cycles.
  - First imem_req appears 1 cycle after rst_n deasserts.
- halt asserted during ISSUE without a handshake: no effect until the handshake occurs.

Decomposition:
- Shared package (also imported by the controller):
  - Opcode constants: LOAD = 0, STORE = 1, JUMP = 2, BEQ = 4, RTYPE = 8, ADDI = 12, SUBI = 13, ANDI = 14, ORI = 15.
  - PcSrc encoding constants.
  - Fetch FSM state enum.
- One natural sub-module: next_pc_calc (combinational), mapping pc, inst, pc_src, branch and zero to next_pc and an illegal flag.

Test Plan:
- Reset then zero-wait memory, ready = 1, with NOPs (0x8040) at addresses 0..3 → imem_addr sequence 0, 1, 2, 3 on every second cycle; retired_cnt = 4 after 8 cycles.
- Jump at pc = 5 (inst 0x2123), pc_src = 1 at handshake → next imem_addr = 0x123; illegal_pcsrc stays 0.
- beq at pc = 0x010 with offset 0xFC:
  - branch = 1, zero = 1 → next pc = 0x00D.
  - Same instruction with zero = 0 → next pc = 0x011.
- Memory with 3 wait cycles plus inst_ready low for 2 cycles → imem_req and imem_addr stable for 4 cycles; inst and pc stable while ready is low; no double retire.
- Sequential fetch at pc = 0xFFF → pc wraps to 0x000. Separately, pc_src = 3 at a handshake → pc + 1 and illegal_pcsrc = 1 (sticky until reset).
- Halt and reset:
  - halt raised mid-FETCH → that fetch completes, the instruction issues, then IDLE with imem_req = 0.
  - rst_n pulsed low mid-FETCH → imem_req = 0 and pc = RESET_PC immediately.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// rtl/inst_fetch_unit_pkg.sv - opcode, PcSrc and fetch-state definitions shared with the controller
package inst_fetch_unit_pkg;

  localparam logic [3:0] OP_LOAD  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_JUMP  = 4'd2;
  localparam logic [3:0] OP_BEQ   = 4'd4;
  localparam logic [3:0] OP_RTYPE = 4'd8;
  localparam logic [3:0] OP_ADDI  = 4'd12;
  localparam logic [3:0] OP_SUBI  = 4'd13;
  localparam logic [3:0] OP_ANDI  = 4'd14;
  localparam logic [3:0] OP_ORI   = 4'd15;

  localparam logic [1:0] PCSRC_SEQ  = 2'd0;
  localparam logic [1:0] PCSRC_JUMP = 2'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_unit_next_pc_calc.sv
// rtl/inst_fetch_unit_next_pc_calc.sv - combinational next-PC selection (sequential, jump, beq)
module inst_fetch_unit_next_pc_calc
  import inst_fetch_unit_pkg::*;
#(
  parameter int PC_W = 12
) (
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] inst_field,
  input  logic [1:0]      pc_src,
  input  logic            branch,
  input  logic            zero,
  output logic [PC_W-1:0] next_pc,
  output logic            illegal
);

  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] br_off;

  // Arithmetic is PC_W wide so every target wraps modulo 2^PC_W.
  always_comb begin
    seq_pc  = pc + PC_W'(1);
    br_off  = {{(PC_W-8){inst_field[7]}}, inst_field[7:0]};
    illegal = pc_src[1];
    if (pc_src == PCSRC_JUMP) begin
      next_pc = inst_field;
    end else if (branch && zero) begin
      next_pc = seq_pc + br_off;
    end else begin
      next_pc = seq_pc;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - PC holder, instruction-memory fetcher and decoder-side issue handshake
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int              PC_W     = 12,
  parameter int              INST_W   = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [PC_W-1:0]   pc,
  input  logic [1:0]        pc_src,
  input  logic              branch,
  input  logic              zero,
  input  logic              halt,
  output logic [15:0]       retired_cnt,
  output logic              illegal_pcsrc
);

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d, next_pc;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [15:0]       retired_q, retired_d;
  logic              illegal_q, illegal_d, next_illegal;

  inst_fetch_unit_next_pc_calc #(.PC_W(PC_W)) u_next_pc (
    .pc         (pc_q),
    .inst_field (inst_q[PC_W-1:0]),
    .pc_src     (pc_src),
    .branch     (branch),
    .zero       (zero),
    .next_pc    (next_pc),
    .illegal    (next_illegal)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    retired_d  = retired_q;
    illegal_d  = illegal_q;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!halt) state_d = FETCH;
      end
      FETCH: begin
        // halt is deliberately not consulted: a started fetch always completes.
        imem_req = 1'b1;
        if (imem_ack) begin
          inst_d  = imem_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        inst_valid = 1'b1;
        if (inst_ready) begin
          pc_d      = next_pc;
          retired_d = retired_q + 16'd1;
          illegal_d = illegal_q | next_illegal;
          state_d   = halt ? IDLE : FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign inst          = inst_q;
  assign retired_cnt   = retired_q;
  assign illegal_pcsrc = illegal_q;

endmodule
